// File: rtl/hypot_pkg.sv
// hypot_pkg: shared FSM encoding, default widths and the round-robin pick
// function for the hypotenuse scheduler.
package hypot_pkg;
  typedef enum logic [2:0] {IDLE, GRANT, START, WAIT, RESP} state_t;
  localparam int W_DEF = 8;
  localparam int TIMEOUT_DEF = 63;
  // Scans ptr, ptr+1, ... modulo n; the reverse loop lets the nearest hit win.
  function automatic logic [2:0] rr_pick(input logic [7:0] valid, input logic [2:0] ptr, input int n = 8);
    logic [2:0] pick;
    int j;
    pick = '0;
    for (int k = n - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= n) j -= n;
      if (valid[j[2:0]]) pick = j[2:0];
    end
    return pick;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker over NREQ valid bits,
// starting the search at i_ptr.
module rr_arbiter import hypot_pkg::*; #(
  parameter int NREQ = 4,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_valid,
  input  logic [IW-1:0]   i_ptr,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);
  logic [7:0] w_v;
  logic [2:0] w_p;
  logic [2:0] w_pick;
  assign w_v = 8'(i_valid);
  assign w_p = 3'(i_ptr);
  assign w_pick = rr_pick(w_v, w_p, NREQ);
  assign o_idx = IW'(w_pick);
  assign o_any = |i_valid;
endmodule

// File: rtl/hypot_sched.sv
// hypot_sched: round-robin scheduler sharing one iterative hypotenuse engine
// between NREQ requesters, with a watchdog that aborts hung operations.
module hypot_sched import hypot_pkg::*; #(
  parameter int NREQ = 4,
  parameter int W = W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic [NREQ-1:0] req_valid,
  input  logic [NREQ*W-1:0] req_x,
  input  logic [NREQ*W-1:0] req_y,
  output logic [NREQ-1:0] req_ready,
  output logic [NREQ-1:0] rsp_valid,
  output logic [W-1:0]    rsp_data,
  output logic            rsp_err,
  output logic            eng_start,
  output logic [W-1:0]    eng_x,
  output logic [W-1:0]    eng_y,
  input  logic            eng_done,
  input  logic [W-1:0]    eng_result,
  output logic            busy
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t r_state, w_state_n;
  logic [IW-1:0] r_ptr, w_ptr_n, r_gnt, w_gnt_n, w_win;
  logic [CW-1:0] r_wd, w_wd_n;
  logic [NREQ-1:0] r_ready, w_ready_n, r_rsp_valid, w_rsp_valid_n, w_win_oh, w_gnt_oh;
  logic [W-1:0] r_rsp_data, w_rsp_data_n, r_x, w_x_n, r_y, w_y_n;
  logic r_rsp_err, w_rsp_err_n, r_start, w_start_n, r_busy, w_busy_n, w_any;
  logic [W-1:0] w_xa [NREQ];
  logic [W-1:0] w_ya [NREQ];
  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign w_xa[g] = req_x[g*W +: W];
    assign w_ya[g] = req_y[g*W +: W];
  end
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_valid(req_valid),
    .i_ptr  (r_ptr),
    .o_idx  (w_win),
    .o_any  (w_any)
  );
  assign w_win_oh = NREQ'(1) << w_win;
  assign w_gnt_oh = NREQ'(1) << r_gnt;
  always_comb begin
    w_state_n = r_state;
    w_ptr_n = r_ptr;
    w_gnt_n = r_gnt;
    w_wd_n = r_wd;
    w_ready_n = r_ready;
    w_rsp_valid_n = r_rsp_valid;
    w_rsp_data_n = r_rsp_data;
    w_rsp_err_n = r_rsp_err;
    w_start_n = r_start;
    w_x_n = r_x;
    w_y_n = r_y;
    case (r_state)
      IDLE: if (w_any) begin
        w_state_n = GRANT;
        w_gnt_n = w_win;
        w_ready_n = w_win_oh;
      end
      GRANT: begin
        w_state_n = START;
        w_ready_n = '0;
        w_x_n = w_xa[r_gnt];
        w_y_n = w_ya[r_gnt];
        w_ptr_n = (r_gnt == IW'(NREQ - 1)) ? '0 : r_gnt + IW'(1);
        w_start_n = 1'b1;
      end
      START: begin
        w_state_n = WAIT;
        w_start_n = 1'b0;
        w_wd_n = '0;
      end
      WAIT: if (eng_done || r_wd == CW'(TIMEOUT - 1)) begin
        // done takes priority over a simultaneous watchdog expiry
        w_state_n = RESP;
        w_rsp_valid_n = w_gnt_oh;
        w_rsp_data_n = eng_done ? eng_result : '0;
        w_rsp_err_n = !eng_done;
      end else begin
        w_wd_n = r_wd + CW'(1);
      end
      RESP: begin
        w_state_n = IDLE;
        w_rsp_valid_n = '0;
      end
      default: w_state_n = IDLE;
    endcase
    w_busy_n = w_state_n != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr <= '0;
      r_gnt <= '0;
      r_wd <= '0;
      r_ready <= '0;
      r_rsp_valid <= '0;
      r_rsp_data <= '0;
      r_rsp_err <= 1'b0;
      r_start <= 1'b0;
      r_x <= '0;
      r_y <= '0;
      r_busy <= 1'b0;
    end else if (ena) begin
      r_state <= w_state_n;
      r_ptr <= w_ptr_n;
      r_gnt <= w_gnt_n;
      r_wd <= w_wd_n;
      r_ready <= w_ready_n;
      r_rsp_valid <= w_rsp_valid_n;
      r_rsp_data <= w_rsp_data_n;
      r_rsp_err <= w_rsp_err_n;
      r_start <= w_start_n;
      r_x <= w_x_n;
      r_y <= w_y_n;
      r_busy <= w_busy_n;
    end
  end
  assign req_ready = r_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data = r_rsp_data;
  assign rsp_err = r_rsp_err;
  assign eng_start = r_start;
  assign eng_x = r_x;
  assign eng_y = r_y;
  assign busy = r_busy;
endmodule

// File: tb/tb_hypot_sched.sv
// tb_hypot_sched: scoreboard bench for hypot_sched with a behavioural
// hypotenuse engine, vector table and hand-written corner sequences.
module tb_hypot_sched;
  localparam int N = 4;
  localparam int W = 8;
  typedef struct {int idx; logic [W-1:0] d; logic e;} rsp_t;
  typedef struct {int idx; logic [W-1:0] x; logic [W-1:0] y; logic [W-1:0] d; int lat;} vec_t;
  logic clk = 0, rst_n = 0, ena = 1;
  logic [N-1:0] req_valid = '0;
  logic [N*W-1:0] req_x = '0, req_y = '0;
  logic [N-1:0] req_ready, rsp_valid;
  logic [W-1:0] rsp_data, eng_x, eng_y, eng_result;
  logic rsp_err, eng_start, busy, eng_done;
  logic auto_done = 0, man_done = 0;
  logic [W-1:0] e_res = '0, man_res = '0;
  int eng_lat = 10, e_cnt = 0;
  bit e_arm = 0;
  int n_chk = 0, n_fail = 0;
  rsp_t exp_q[$];
  int gnt_q[$];
  int rem[N];
  vec_t tv[8];
  always #5 clk = ~clk;
  hypot_sched #(.NREQ(N), .W(W), .TIMEOUT(63)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .eng_start(eng_start), .eng_x(eng_x), .eng_y(eng_y), .eng_done(eng_done),
    .eng_result(eng_result), .busy(busy)
  );
  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction
  function automatic logic [W-1:0] hyp(input int x, input int y);
    int s = x * x + y * y;
    int r = 0;
    while ((r + 1) * (r + 1) <= s) r++;
    if (s - r * r > r) r++;
    return W'(r);
  endfunction
  function automatic int rem_sum();
    int s = 0;
    for (int i = 0; i < N; i++) s += rem[i];
    return s;
  endfunction
  // engine model: done pulses eng_lat cycles after start; eng_lat=0 never finishes
  assign eng_done = auto_done | man_done;
  assign eng_result = auto_done ? e_res : man_res;
  always @(negedge clk) begin
    auto_done = 0;
    if (!rst_n) e_arm = 0;
    else begin
      if (e_arm) begin
        e_cnt++;
        if (e_cnt == eng_lat) begin auto_done = 1; e_arm = 0; end
      end
      if (eng_start) begin e_arm = eng_lat > 0; e_cnt = 0; e_res = hyp(eng_x, eng_y); end
    end
  end
  always @(negedge clk) begin : mon
    rsp_t r;
    for (int i = 0; i < N; i++) if (req_ready[i]) gnt_q.push_back(i);
    if (rsp_valid != 0) begin
      if (exp_q.size() == 0) check("unexpected_rsp", 32'(rsp_valid), 0);
      else begin
        r = exp_q.pop_front();
        check("rsp_valid", 32'(rsp_valid), 32'(1) << r.idx);
        check("rsp_data", 32'(rsp_data), 32'(r.d));
        check("rsp_err", 32'(rsp_err), 32'(r.e));
      end
    end
  end
  task automatic set_ops(input int idx, input logic [W-1:0] x, input logic [W-1:0] y);
    req_x[idx*W +: W] = x;
    req_y[idx*W +: W] = y;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; ena = 1; req_valid = '0; man_done = 0;
    for (int i = 0; i < N; i++) rem[i] = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask
  task automatic issue(input int idx, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] d, input logic e, input int exp_lat);
    int n = 0;
    @(negedge clk);
    set_ops(idx, x, y);
    req_valid[idx] = 1;
    exp_q.push_back('{idx, d, e});
    @(negedge clk);
    check("ready_lat", 32'(req_ready), 32'(1) << idx);
    req_valid[idx] = 0;
    @(negedge clk);
    check("start_lat", 32'(eng_start), 1);
    check("eng_x", 32'(eng_x), 32'(x));
    check("eng_y", 32'(eng_y), 32'(y));
    while (rsp_valid == 0 && n < 200) begin @(negedge clk); n++; end
    check("rsp_lat", n, exp_lat);
    @(negedge clk);
    check("busy_after", 32'(busy), 0);
  endtask
  task automatic rr_run(input int bound);
    int c = 0;
    forever begin
      for (int i = 0; i < N; i++) if (req_ready[i] && rem[i] > 0) begin
        rem[i]--;
        if (rem[i] == 0) req_valid[i] = 0;
      end
      if (rem_sum() == 0 && !busy && exp_q.size() == 0) break;
      if (c++ >= bound) begin check("rr_run_bound", rem_sum() + exp_q.size(), 0); break; end
      @(negedge clk);
    end
  endtask
  initial begin : watchdog
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "hang");
  end
  initial begin
    int bad;
    int exp_fair[6] = '{0, 1, 2, 3, 0, 1};
    logic [W-1:0] fair_d[N] = '{8'd0, 8'd1, 8'd3, 8'd4};
    tv[0] = '{0, 8'd3, 8'd4, 8'd5, 10};
    tv[1] = '{1, 8'd6, 8'd8, 8'd10, 1};
    tv[2] = '{2, 8'd5, 8'd12, 8'd13, 2};
    tv[3] = '{3, 8'd8, 8'd15, 8'd17, 3};
    tv[4] = '{1, 8'd1, 8'd1, 8'd1, 4};
    tv[5] = '{2, 8'd2, 8'd2, 8'd3, 5};
    tv[6] = '{0, 8'd0, 8'd0, 8'd0, 2};
    tv[7] = '{3, 8'd120, 8'd160, 8'd200, 7};
    for (int i = 0; i < N; i++) rem[i] = 0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_data", 32'(rsp_data), 0);
    check("rst_rsp_err", 32'(rsp_err), 0);
    check("rst_start", 32'(eng_start), 0);
    check("rst_eng_xy", {eng_x, eng_y}, 0);
    check("rst_busy", 32'(busy), 0);
    rst_n = 1;
    // table-driven single requests; first entry is the 3,4 -> 5 case
    for (int k = 0; k < 8; k++) begin
      eng_lat = tv[k].lat;
      issue(tv[k].idx, tv[k].x, tv[k].y, tv[k].d, 1'b0, tv[k].lat + 1);
    end
    // fairness with all four requesters holding valid
    do_reset();
    eng_lat = 3;
    gnt_q.delete();
    for (int i = 0; i < N; i++) set_ops(i, W'(i), W'(i));
    rem = '{2, 2, 1, 1};
    for (int k = 0; k < 6; k++) exp_q.push_back('{exp_fair[k], fair_d[exp_fair[k]], 1'b0});
    req_valid = '1;
    rr_run(400);
    check("fair_count", gnt_q.size(), 6);
    for (int k = 0; k < 6 && k < gnt_q.size(); k++) check("fair_gnt", gnt_q[k], exp_fair[k]);
    // pointer wrap: req2 first, then req0/req3 pending -> 3 then 0
    do_reset();
    eng_lat = 3;
    gnt_q.delete();
    set_ops(0, 8'd6, 8'd8); set_ops(2, 8'd3, 8'd4); set_ops(3, 8'd5, 8'd12);
    exp_q.push_back('{2, 8'd5, 1'b0});
    exp_q.push_back('{3, 8'd13, 1'b0});
    exp_q.push_back('{0, 8'd10, 1'b0});
    rem[2] = 1; req_valid[2] = 1;
    @(negedge clk);
    rem[0] = 1; rem[3] = 1; req_valid[0] = 1; req_valid[3] = 1;
    rr_run(300);
    check("wrap_count", gnt_q.size(), 3);
    for (int k = 0; k < 3 && k < gnt_q.size(); k++) check("wrap_gnt", gnt_q[k], (k == 0) ? 2 : (k == 1) ? 3 : 0);
    // watchdog timeout, then a stray done, then normal service
    eng_lat = 0;
    issue(1, 8'd9, 8'd9, 8'd0, 1'b1, 64);
    man_res = 8'd77; man_done = 1;
    @(negedge clk);
    man_done = 0;
    bad = 0;
    repeat (5) begin @(negedge clk); bad += (rsp_valid != 0 || busy) ? 1 : 0; end
    check("stray_done_ignored", bad, 0);
    eng_lat = 6;
    issue(3, 8'd6, 8'd8, 8'd10, 1'b0, 7);
    // enable freeze during WAIT with done arriving while frozen
    eng_lat = 0;
    man_res = 8'd42;
    exp_q.push_back('{0, 8'd42, 1'b0});
    @(negedge clk);
    set_ops(0, 8'd1, 8'd2); req_valid[0] = 1;
    @(negedge clk);
    check("frz_ready", 32'(req_ready), 1);
    req_valid[0] = 0;
    repeat (6) @(negedge clk);
    ena = 0;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      man_done = (c == 3);
      bad += (rsp_valid != 0 || !busy) ? 1 : 0;
    end
    man_done = 0;
    check("frz_no_rsp", bad, 0);
    ena = 1;
    bad = 0;
    repeat (50) begin @(negedge clk); bad += (rsp_valid != 0) ? 1 : 0; end
    check("frz_no_timeout", bad, 0);
    man_done = 1;
    @(negedge clk);
    man_done = 0;
    check("frz_rsp", 32'(rsp_valid), 1);
    repeat (2) @(negedge clk);
    // asynchronous reset in the middle of WAIT
    @(negedge clk);
    set_ops(2, 8'd9, 8'd9); req_valid[2] = 1;
    @(negedge clk);
    req_valid[2] = 0;
    repeat (5) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 1);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    check("arst_ready", 32'(req_ready), 0);
    check("arst_rsp", {rsp_valid, rsp_err, rsp_data}, 0);
    check("arst_start", 32'(eng_start), 0);
    check("arst_eng_xy", {eng_x, eng_y}, 0);
    check("arst_busy", 32'(busy), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    eng_lat = 4;
    gnt_q.delete();
    set_ops(1, 8'd3, 8'd4); set_ops(3, 8'd8, 8'd6);
    exp_q.push_back('{1, 8'd5, 1'b0});
    exp_q.push_back('{3, 8'd10, 1'b0});
    rem[1] = 1; rem[3] = 1; req_valid[1] = 1; req_valid[3] = 1;
    rr_run(200);
    check("post_rst_count", gnt_q.size(), 2);
    if (gnt_q.size() > 0) check("post_rst_first", gnt_q[0], 1);
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
